// File: rtl/core_sched.sv
// Start-pulse scheduler for the md5crypt core array: per-core start strobes,
// sequence numbers and context select, with run/drain control and a period-latched core mask.
module core_sched #(
   parameter int N_CORES       = 3,
   parameter int N_SEQ         = 2,
   parameter int PERIOD        = 288,
   parameter int COMP_INTERVAL = 24,
   parameter int N_CTX         = 2,
   localparam int CNT_MSB      = $clog2(PERIOD) - 1,
   localparam int SEQ_MSB      = (N_SEQ > 1) ? $clog2(N_SEQ) - 1 : 0,
   localparam int CTX_MSB      = $clog2(N_CTX) - 1
) (
   input  logic                             CLK,
   input  logic                             RESET_N,
   input  logic                             en,
   input  logic [N_CORES-1:0]               core_mask,
   output logic [N_CORES-1:0]               core_start,
   output logic [N_CORES*(SEQ_MSB+1)-1:0]   seq_num,
   output logic [CTX_MSB:0]                 ctx_num,
   output logic                             period_start,
   output logic                             busy
);

   localparam int SEG   = PERIOD / N_SEQ;
   localparam int CNT_W = CNT_MSB + 1;
   localparam int SEQ_W = SEQ_MSB + 1;
   localparam logic [CNT_MSB:0] CNT_LAST = CNT_W'(PERIOD - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [CNT_MSB:0]           cnt_q, cnt_d;
   logic [N_CORES-1:0]         mask_q, mask_d;
   logic [N_CORES-1:0]         start_q, start_d;
   logic [N_CORES*SEQ_W-1:0]   seq_q, seq_d;
   logic [CTX_MSB:0]           ctx_q, ctx_d;
   logic                       pstart_q, pstart_d;
   logic                       busy_q, busy_d;
   logic [N_CORES*N_SEQ-1:0]   slot_hit;
   logic                       running;
   logic                       last;

   assign running = (state_q != S_IDLE);
   assign last    = (cnt_q == CNT_LAST);

   // Each (core, sequence) pair owns two fixed slot positions within the period.
   genvar gi, gs;
   generate
      for (gi = 0; gi < N_CORES; gi++) begin : g_core
         for (gs = 0; gs < N_SEQ; gs++) begin : g_seq
            localparam int SLOT_A = gs * SEG + 2 * gi * COMP_INTERVAL;
            localparam int SLOT_B = SLOT_A + COMP_INTERVAL - 1;
            assign slot_hit[gi*N_SEQ+gs] = (cnt_q == CNT_W'(SLOT_A)) || (cnt_q == CNT_W'(SLOT_B));
         end
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      mask_d   = mask_q;
      start_d  = '0;
      seq_d    = seq_q;
      ctx_d    = '0;
      pstart_d = 1'b0;

      case (state_q)
         S_IDLE:  if (en) state_d = S_RUN;
         S_RUN:   if (!en) state_d = last ? S_IDLE : S_DRAIN;
         S_DRAIN: begin
            if (en)        state_d = S_RUN;
            else if (last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (running) begin
         cnt_d    = last ? '0 : cnt_q + CNT_W'(1);
         ctx_d    = cnt_q[CTX_MSB:0];
         pstart_d = (cnt_q == '0);
      end

      // The mask only moves at period boundaries so a period is never split.
      if (!running || last) mask_d = core_mask;

      for (int i = 0; i < N_CORES; i++) begin
         for (int s = 0; s < N_SEQ; s++) begin
            if (running && mask_q[i] && slot_hit[i*N_SEQ+s]) begin
               start_d[i]                = 1'b1;
               seq_d[i*SEQ_W +: SEQ_W]   = SEQ_W'(s);
            end
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mask_q   <= '0;
         start_q  <= '0;
         seq_q    <= '0;
         ctx_q    <= '0;
         pstart_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         start_q  <= start_d;
         seq_q    <= seq_d;
         ctx_q    <= ctx_d;
         pstart_q <= pstart_d;
         busy_q   <= busy_d;
      end
   end

   assign core_start   = start_q;
   assign seq_num      = seq_q;
   assign ctx_num      = ctx_q;
   assign period_start = pstart_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_core_sched.sv
// Bench for core_sched: default and 4-core instances against a slot-arithmetic reference model,
// plus a directed vector table and hand-written drain/boundary/reset sequences.
module tb_core_sched;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       en = 1'b0;
   logic [2:0] cm0 = '0;
   logic [3:0] cm1 = '0;

   logic [2:0] cs0, sq0;
   logic [0:0] cx0;
   logic       ps0, bz0;
   logic [3:0] cs1;
   logic [7:0] sq1;
   logic [1:0] cx1;
   logic       ps1, bz1;

   core_sched dut0 (
      .CLK(CLK), .RESET_N(RESET_N), .en(en), .core_mask(cm0),
      .core_start(cs0), .seq_num(sq0), .ctx_num(cx0), .period_start(ps0), .busy(bz0)
   );

   core_sched #(.N_CORES(4), .N_SEQ(3), .PERIOD(300), .COMP_INTERVAL(12), .N_CTX(4)) dut1 (
      .CLK(CLK), .RESET_N(RESET_N), .en(en), .core_mask(cm1),
      .core_start(cs1), .seq_num(sq1), .ctx_num(cx1), .period_start(ps1), .busy(bz1)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: one entry per instance
   int       P_NC[2]  = '{3, 4};
   int       P_NS[2]  = '{2, 3};
   int       P_PER[2] = '{288, 300};
   int       P_CI[2]  = '{24, 12};
   int       P_NX[2]  = '{2, 4};
   int       m_mode[2];           // 0 idle, 1 run, 2 drain
   int       m_cnt[2];
   bit [3:0] m_mask[2];
   bit [3:0] e_start[2];
   int       e_seq[2][4];
   int       e_ctx[2];
   bit       e_ps[2];
   bit       e_busy[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_cnt[k] = 0; m_mask[k] = '0;
         e_start[k] = '0; e_ctx[k] = 0; e_ps[k] = 1'b0; e_busy[k] = 1'b0;
         for (int i = 0; i < 4; i++) e_seq[k][i] = 0;
      end
   endtask

   task automatic model_step(input int k, input bit e, input bit [3:0] cm);
      int seg, off, s, nxt;
      bit run_v, last_v;
      seg    = P_PER[k] / P_NS[k];
      run_v  = (m_mode[k] != 0);
      last_v = (m_cnt[k] == P_PER[k] - 1);
      e_start[k] = '0;
      if (run_v) begin
         off = m_cnt[k] % seg;
         s   = m_cnt[k] / seg;
         for (int i = 0; i < P_NC[k]; i++) begin
            if (m_mask[k][i] && (off == 2*i*P_CI[k] || off == 2*i*P_CI[k] + P_CI[k] - 1)) begin
               e_start[k][i] = 1'b1;
               e_seq[k][i]   = s;
            end
         end
      end
      e_ctx[k] = run_v ? m_cnt[k] % P_NX[k] : 0;
      e_ps[k]  = run_v && (m_cnt[k] == 0);
      if (m_mode[k] == 0) nxt = e ? 1 : 0;
      else                nxt = e ? 1 : (last_v ? 0 : 2);
      if (!run_v || last_v) m_mask[k] = cm;
      m_cnt[k]  = run_v ? (m_cnt[k] + 1) % P_PER[k] : 0;
      m_mode[k] = nxt;
      e_busy[k] = (nxt != 0);
   endtask

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) model_reset();
      else begin
         model_step(0, en, {1'b0, cm0});
         model_step(1, en, cm1);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("start0", int'(cs0), int'(e_start[0][2:0]));
      for (int i = 0; i < 3; i++) chk("seq0", int'(sq0[i]), e_seq[0][i]);
      chk("ctx0", int'(cx0), e_ctx[0]);
      chk("pstart0", int'(ps0), int'(e_ps[0]));
      chk("busy0", int'(bz0), int'(e_busy[0]));
      chk("start1", int'(cs1), int'(e_start[1]));
      for (int i = 0; i < 4; i++) chk("seq1", int'(sq1[2*i +: 2]), e_seq[1][i]);
      chk("ctx1", int'(cx1), e_ctx[1]);
      chk("pstart1", int'(ps1), int'(e_ps[1]));
      chk("busy1", int'(bz1), int'(e_busy[1]));
   endtask

   task automatic cycle();
      @(negedge CLK);
      compare_model();
   endtask

   task automatic run_until(input int c, output int n0, output int n1, output int n2);
      n0 = 0; n1 = 0; n2 = 0;
      for (int t = 0; t < 2000; t++) begin
         cycle();
         n0 += int'(cs0[0]); n1 += int'(cs0[1]); n2 += int'(cs0[2]);
         if (m_cnt[0] == c) break;
      end
      chk("reach_cnt", m_cnt[0], c);
   endtask

   typedef struct {
      int       c;
      bit [2:0] st;
      bit [2:0] sq;
      bit       ps;
   } vec_t;

   vec_t     tbl[16];
   bit [2:0] o_st[288];
   bit [2:0] o_sq[288];
   bit       o_ps[288];
   bit       o1_st3[300];
   bit [1:0] o1_sq3[300];
   int       hit1[6] = '{72, 83, 172, 183, 272, 283};
   int       hsq1[6] = '{0, 0, 1, 1, 2, 2};

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n0, n1, n2, tot, lows;

      tbl[0]  = '{0,   3'b001, 3'b000, 1'b1};
      tbl[1]  = '{1,   3'b000, 3'b000, 1'b0};
      tbl[2]  = '{23,  3'b001, 3'b000, 1'b0};
      tbl[3]  = '{24,  3'b000, 3'b000, 1'b0};
      tbl[4]  = '{48,  3'b010, 3'b000, 1'b0};
      tbl[5]  = '{71,  3'b010, 3'b000, 1'b0};
      tbl[6]  = '{96,  3'b100, 3'b000, 1'b0};
      tbl[7]  = '{119, 3'b100, 3'b000, 1'b0};
      tbl[8]  = '{144, 3'b001, 3'b001, 1'b0};
      tbl[9]  = '{145, 3'b000, 3'b001, 1'b0};
      tbl[10] = '{167, 3'b001, 3'b001, 1'b0};
      tbl[11] = '{192, 3'b010, 3'b011, 1'b0};
      tbl[12] = '{215, 3'b010, 3'b011, 1'b0};
      tbl[13] = '{240, 3'b100, 3'b111, 1'b0};
      tbl[14] = '{263, 3'b100, 3'b111, 1'b0};
      tbl[15] = '{287, 3'b000, 3'b111, 1'b0};

      // Reset state
      repeat (3) cycle();
      chk("rst_start", int'(cs0), 0);
      chk("rst_seq", int'(sq0), 0);
      chk("rst_ctx", int'(cx0), 0);
      chk("rst_pstart", int'(ps0), 0);
      chk("rst_busy", int'(bz0), 0);
      RESET_N = 1'b1;
      repeat (2) cycle();

      // First period, full masks: record and compare against the vector table
      en = 1'b1; cm0 = 3'b111; cm1 = 4'hF;
      for (int j = 0; j < 302; j++) begin
         cycle();
         if (j == 0) chk("busy_rise", int'(bz0), 1);
         if (j >= 1 && j - 1 < 288) begin
            o_st[j-1] = cs0; o_sq[j-1] = sq0; o_ps[j-1] = ps0;
         end
         if (j >= 1 && j - 1 < 300) begin
            o1_st3[j-1] = cs1[3]; o1_sq3[j-1] = sq1[7:6];
         end
      end
      for (int v = 0; v < 16; v++) begin
         chk($sformatf("tbl_start@%0d", tbl[v].c), int'(o_st[tbl[v].c]), int'(tbl[v].st));
         chk($sformatf("tbl_seq@%0d", tbl[v].c), int'(o_sq[tbl[v].c]), int'(tbl[v].sq));
         chk($sformatf("tbl_pstart@%0d", tbl[v].c), int'(o_ps[tbl[v].c]), int'(tbl[v].ps));
      end
      tot = 0;
      for (int c = 0; c < 300; c++) tot += int'(o1_st3[c]);
      chk("p4_core3_count", tot, 6);
      for (int v = 0; v < 6; v++) begin
         chk($sformatf("p4_core3_start@%0d", hit1[v]), int'(o1_st3[hit1[v]]), 1);
         chk($sformatf("p4_core3_seq@%0d", hit1[v]), int'(o1_sq3[hit1[v]]), hsq1[v]);
      end

      // Mask 101 latched at the period boundary, 111 applied mid-period is deferred
      run_until(10, n0, n1, n2);
      cm0 = 3'b101;
      run_until(0, n0, n1, n2);
      run_until(100, n0, n1, n2);
      tot = n1;
      cm0 = 3'b111;
      run_until(0, n0, n1, n2);
      chk("mask_core1_period", tot + n1, 0);
      run_until(60, n0, n1, n2);
      chk("mask_core1_next", n1, 1);

      // Drain: remaining slots fire, then idle
      run_until(150, n0, n1, n2);
      en = 1'b0;
      n0 = 0; n1 = 0; n2 = 0;
      for (int t = 0; t < 400; t++) begin
         cycle();
         n0 += int'(cs0[0]); n1 += int'(cs0[1]); n2 += int'(cs0[2]);
         if (!bz0) break;
      end
      chk("drain_busy_fall", int'(bz0), 0);
      chk("drain_core0", n0, 1);
      chk("drain_core1", n1, 2);
      chk("drain_core2", n2, 2);
      tot = 0;
      for (int t = 0; t < 300; t++) begin
         cycle();
         tot += int'(cs0 != 3'b000);
      end
      chk("idle_no_strobes", tot, 0);

      // Re-assert during drain: no gap
      en = 1'b1;
      run_until(150, n0, n1, n2);
      en = 1'b0;
      run_until(200, n0, n1, n2);
      en = 1'b1;
      lows = 0;
      for (int t = 0; t < 300; t++) begin
         cycle();
         lows += int'(!bz0);
      end
      chk("rerun_no_gap", lows, 0);

      // DRAIN rescued at PERIOD-1: cnt=0 slot still fires
      run_until(150, n0, n1, n2);
      en = 1'b0;
      run_until(287, n0, n1, n2);
      en = 1'b1;
      cycle(); cycle();
      chk("drain_rescue_start", int'(cs0), 1);
      chk("drain_rescue_busy", int'(bz0), 1);

      // RUN stopped at PERIOD-1: straight to IDLE, no cnt=0 strobe
      run_until(287, n0, n1, n2);
      en = 1'b0;
      cycle();
      chk("run_stop_busy", int'(bz0), 0);
      cycle();
      chk("run_stop_nostrobe", int'(cs0), 0);

      // Reset mid-run
      en = 1'b1;
      run_until(96, n0, n1, n2);
      RESET_N = 1'b0;
      #1;
      chk("midrst_start", int'(cs0), 0);
      chk("midrst_seq", int'(sq0), 0);
      chk("midrst_ctx", int'(cx0), 0);
      chk("midrst_busy", int'(bz0), 0);
      chk("midrst_start1", int'(cs1), 0);
      cycle(); cycle();
      RESET_N = 1'b1;
      cycle(); cycle();
      chk("postrst_first_strobe", int'(cs0), 1);

      // Randomized run against the model
      for (int t = 0; t < 4000; t++) begin
         cycle();
         if ($urandom_range(39) == 0) en = ~en;
         if ($urandom_range(29) == 0) begin
            cm0 = 3'($urandom);
            cm1 = 4'($urandom);
         end
         if (!RESET_N) RESET_N = 1'b1;
         else if ($urandom_range(1499) == 0) RESET_N = 1'b0;
      end
      RESET_N = 1'b1;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_sched.md
# core_sched

Parametrised start-pulse scheduler for the md5crypt core array: generalises the fixed 3-core / 2-sequence / 288-cycle controller to N_CORES cores, N_SEQ sequences per period, N_CTX interleaved contexts and a configurable period. It adds run control with graceful drain, a per-core enable mask latched at period boundaries, and period and busy status. It sits between the arbiter and the core array and drives each core's start strobe, sequence number and the shared context select.

## Interface
- N_CORES, 3: number of cores scheduled.
- N_SEQ, 2: sequences (start windows) per period. Legal range ≥1.
- PERIOD, 288: cycles per schedule period. Must be divisible by N_SEQ. SEG = PERIOD/N_SEQ.
- COMP_INTERVAL, 24: cycles between a core's two start pulses within one sequence window. Must be ≥2. Required: 2*N_CORES*COMP_INTERVAL ≤ SEG.
- N_CTX, 2: interleaved contexts. ctx_num = cnt mod N_CTX. Must be a power of 2, ≥2.
- CNT_MSB, `MSB(PERIOD-1); SEQ_MSB, `MSB(N_SEQ-1) (0 when N_SEQ=1); CTX_MSB, `MSB(N_CTX-1): derived.
- CLK  in  1  clock; single clock domain.
- RESET_N  in  1  asynchronous, active-low reset.
- en  in  1  run request; level-sensitive.
- core_mask  in  N_CORES  per-core enable; bit i=1 allows core i to be started.
- core_start  out  N_CORES  one-cycle start strobes.
- seq_num  out  N_CORES*(SEQ_MSB+1)  packed; field i is core i's current sequence index.
- ctx_num  out  CTX_MSB+1  context select.
- period_start  out  1  one-cycle pulse at the start of each running period.
- busy  out  1  high while not IDLE.

## Operation
- States:
  - IDLE: cnt held at 0.
  - RUN: cnt counts 0..PERIOD-1 and wraps to 0.
  - DRAIN: counts like RUN; returns to IDLE after cnt==PERIOD-1.
- Transitions:
  - IDLE→RUN when en=1.
  - RUN→DRAIN when en=0.
  - DRAIN→RUN when en=1, with no cnt disturbance.
  - DRAIN→IDLE at the edge where cnt==PERIOD-1 and en=0.
  - The RUN→DRAIN and DRAIN-exit conditions are both evaluated at the same edge. If RUN has en=0 and cnt==PERIOD-1, go directly to IDLE.
- Mask latch: mask_r <= core_mask every cycle in IDLE, and at cnt==PERIOD-1 in RUN/DRAIN. It is never updated mid-period.
- Slots, in RUN/DRAIN:
  - Core i, sequence s (0..N_SEQ-1) fires at cnt == s*SEG + 2*i*COMP_INTERVAL.
  - It fires again at cnt == s*SEG + 2*i*COMP_INTERVAL + COMP_INTERVAL-1.
- On a slot hit with mask_r[i]=1:
  - core_start[i] <= 1 on the next cycle.
  - seq_num field i <= s, on the same cycle.
- core_start bits are otherwise 0. Each strobe is exactly one cycle.
- A masked core gets no strobe, and its seq_num is held.
- ctx_num <= cnt[CTX_MSB:0] while running, and 0 in IDLE.
- period_start <= 1 for one cycle after a running cycle with cnt==0.
- busy is registered from the next state, so it rises together with the IDLE→RUN transition.
- Arithmetic: cnt is CNT_MSB+1 bits wide. Wrap is by explicit compare to PERIOD-1, never natural overflow. Slot constants are computed at elaboration.

## Timing
- Reset (async assert; release synchronous to CLK):
  - State IDLE; cnt=0; mask_r=0.
  - core_start, seq_num, ctx_num, period_start and busy all 0.
- en sampled 1 at edge k (IDLE): at edge k+1 state=RUN and busy=1. The cycle after edge k+1 is the first running cycle with cnt=0.
- Every output is registered, one cycle after the cnt value it decodes:
  - core_start[0] and period_start are first high after edge k+2.
  - ctx_num tracks cnt with the same one-cycle lag.
- Stop: en dropped mid-period → all remaining slots of the period still fire. The last possible strobe falls at most one cycle after the cycle with cnt==PERIOD-1. busy falls at the same edge the state enters IDLE.
- Reset asserted mid-period clears all outputs immediately. A strobe in flight is cut short, which is legal.
- Mask change mid-period has no effect until the next period.

## Test plan
- Default params: reset, en=1, core_mask=3'b111. core_start[0] fires at cnt 0, 23, 144, 167; core 1 at 48, 71, 192, 215; core 2 at 96, 119, 240, 263. seq_num fields are 0 for the first two pulses of each core and 1 for the last two. Pattern repeats every 288 cycles; period_start pulses every 288.
- Default params, core_mask=3'b101, then changed to 3'b111 at cnt=100: core 1 gets no strobes for the rest of that period. Core 1 first fires at cnt 48 of the next period. seq_num field 1 is held at 0 until then.
- Drain: en dropped at cnt=150. Core 0's 167 strobe and the 192 to 263 strobes still fire. busy falls at the period end and no further strobes occur. en reasserted at cnt=200 instead → continuous run with no gap.
- Reset mid-run: RESET_N=0 at cnt=96. All outputs read 0 within the same cycle. After release with en=1, the first strobe appears 2 cycles later at cnt 0.
- Params N_CORES=4, N_SEQ=3, PERIOD=300, COMP_INTERVAL=12, N_CTX=4: core 3 fires at 72, 83, 172, 183, 272, 283 with seq_num 0, 0, 1, 1, 2, 2. ctx_num cycles 0..3.
- Boundary: en=1 exactly at cnt==PERIOD-1 while in DRAIN → stays running, and the cnt=0 slots fire. en=0 at cnt==PERIOD-1 in RUN → IDLE next cycle, with no cnt=0 strobes.
